// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter and its ALU.
package alu_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [2:0] op_t;

  localparam int  DEFAULT_WIDTH = 16;

  localparam op_t OP_ADD     = 3'd0;
  localparam op_t OP_SUB     = 3'd1;
  localparam op_t OP_AND     = 3'd2;
  localparam op_t OP_OR      = 3'd3;
  localparam op_t OP_XOR     = 3'd4;
  localparam op_t OP_SHL     = 3'd5;
  localparam op_t OP_SHR     = 3'd6;
  localparam op_t OP_ILLEGAL = 3'd7;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: add, sub, and, or, xor, shift left, shift right.
// Shift amounts use the low log2(WIDTH) bits of b; illegal opcodes give 0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

  // Opcode decode
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << sh;
      OP_SHR:  res = a >> sh;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters. One result
// register; a new request can be accepted in the same cycle the current
// owner consumes its result, so back-to-back traffic runs at 1 op/cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  input  logic [NREQ-1:0][2:0]       req_op,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [WIDTH-1:0]           rsp_res,
  output logic                       rsp_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  state_t          state, state_d;
  logic [IW-1:0]   owner, last_grant, win;
  logic            found, can_accept, xfer;
  logic [WIDTH-1:0] res_q, alu_res;
  logic            err_q;
  op_t             op_sel;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Accept when the result register is free or is being drained this cycle
  always_comb begin
    can_accept = (state == IDLE) || rsp_ready[owner];
    req_ready  = '0;
    if (rst_n && found && can_accept) req_ready[win] = 1'b1;
  end

  assign xfer   = |(req_valid & req_ready);
  assign op_sel = req_op[win];

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (req_a[win]),
    .b   (req_b[win]),
    .op  (op_sel),
    .res (alu_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state: fill on transfer, empty when owner consumes without refill
  always_comb begin
    state_d = state;
    if (xfer)                                  state_d = HOLD;
    else if (state == HOLD && rsp_ready[owner]) state_d = IDLE;
  end

  // Result register, owner and round-robin pointer; all load only on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q      <= '0;
      err_q      <= 1'b0;
      owner      <= '0;
      last_grant <= LAST;
    end else if (xfer) begin
      res_q      <= (op_sel == OP_ILLEGAL) ? '0 : alu_res;
      err_q      <= (op_sel == OP_ILLEGAL);
      owner      <= win;
      last_grant <= win;
    end
  end

  // Route valid to the owner only; result bus is driven straight from the register
  always_comb begin
    rsp_valid = '0;
    if (state == HOLD) rsp_valid[owner] = 1'b1;
  end

  assign rsp_res = res_q;
  assign rsp_err = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 2;

  logic                       clk;
  logic                       rst_n;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0][2:0]       req_op;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready;
  logic [WIDTH-1:0]           rsp_res;
  logic                       rsp_err;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: one pending result slot, round-robin pointer
  bit      m_pend;
  int      m_owner;
  longint  m_res;
  bit      m_err;
  int      m_lg;
  int      last_xfer;

  function automatic longint ref_alu(longint a, longint b, int op);
    longint mask = (longint'(1) << WIDTH) - 1;
    int     s    = int'(b % WIDTH);
    case (op)
      0: return (a + b) & mask;
      1: return (a - b + (mask + 1)) & mask;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a * (longint'(1) << s)) & mask;
      6: return a / (longint'(1) << s);
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_pend = 0; m_owner = 0; m_res = 0; m_err = 0; m_lg = NREQ - 1;
  endfunction

  // One clock: called just after a posedge with inputs already driven.
  // Checks outputs at the negedge, then advances the model at the posedge.
  task automatic cycle();
    int w;
    bit can;
    logic [NREQ-1:0] exp_rdy, exp_vld;
    @(negedge clk);
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i = (m_lg + k) % NREQ;
      if (w < 0 && req_valid[i]) w = i;
    end
    can = !m_pend || rsp_ready[m_owner];
    exp_rdy = '0;
    if (w >= 0 && can) exp_rdy[w] = 1'b1;
    exp_vld = '0;
    if (m_pend) exp_vld[m_owner] = 1'b1;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_err++; $display("FAIL req_ready: got %b want %b @%0t", req_ready, exp_rdy, $time);
    end
    n_cmp++;
    if (rsp_valid !== exp_vld) begin
      n_err++; $display("FAIL rsp_valid: got %b want %b @%0t", rsp_valid, exp_vld, $time);
    end
    if (m_pend) begin
      n_cmp++;
      if (rsp_res !== WIDTH'(m_res) || rsp_err !== m_err) begin
        n_err++; $display("FAIL rsp_data: got %h/%b want %h/%b @%0t",
                          rsp_res, rsp_err, WIDTH'(m_res), m_err, $time);
      end
    end
    @(posedge clk);
    last_xfer = -1;
    if (w >= 0 && can) begin
      m_res   = ref_alu(longint'(req_a[w]), longint'(req_b[w]), int'(req_op[w]));
      m_err   = (req_op[w] == 3'd7);
      m_pend  = 1; m_owner = w; m_lg = w; last_xfer = w;
    end else if (m_pend && rsp_ready[m_owner]) begin
      m_pend = 0;
    end
    #1;
  endtask

  task automatic drain();
    req_valid = '0; rsp_ready = '1;
    cycle(); cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1; rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = WIDTH'($urandom); req_b[i] = WIDTH'($urandom); req_op[i] = 3'($urandom);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== '0 || rsp_res !== '0 || rsp_err !== 1'b0 || req_ready !== '0) begin
      n_err++; $display("FAIL reset_state: got v=%b r=%h e=%b rdy=%b want all zero",
                        rsp_valid, rsp_res, rsp_err, req_ready);
    end
    rst_n = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    req_valid = 2'b01; rsp_ready = '1;
    req_a[0] = 16'h006A; req_b[0] = 16'h003B; req_op[0] = 3'd0;
    cycle();
    n_cmp++;
    if (last_xfer != 0) begin
      n_err++; $display("FAIL single_grant: got %0d want 0", last_xfer);
    end
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b01 || rsp_res !== 16'h00A5 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: got %b/%h/%b want 01/00a5/0", rsp_valid, rsp_res, rsp_err);
    end
    @(posedge clk); #1;
    m_pend = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    int nx = 0, prev = -1, alt_bad = 0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_a[i] = WIDTH'($urandom); req_b[i] = WIDTH'($urandom); req_op[i] = 3'($urandom_range(0, 6));
      end
      cycle();
      if (last_xfer >= 0) nx++;
      if (last_xfer == prev) alt_bad++;
      prev = last_xfer;
    end
    n_cmp++;
    if (nx != 10 || alt_bad != 0) begin
      n_err++; $display("FAIL b2b: transfers %0d repeats %0d want 10 transfers 0 repeats", nx, alt_bad);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] held;
    int bad = 0;
    req_valid = 2'b01; rsp_ready = '1;
    req_a[0] = WIDTH'($urandom); req_b[0] = WIDTH'($urandom); req_op[0] = 3'd4;
    cycle();
    req_valid = 2'b10; rsp_ready = 2'b10;   // non-owner ready must be ignored
    req_a[1] = WIDTH'($urandom); req_b[1] = WIDTH'($urandom); req_op[1] = 3'd1;
    held = rsp_res;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (rsp_res !== held || last_xfer != -1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL stall_hold: %0d unstable/accepted cycles want 0", bad);
    end
    rsp_ready = 2'b01;
    cycle();
    n_cmp++;
    if (last_xfer != 1) begin
      n_err++; $display("FAIL stall_release: grant %0d want 1", last_xfer);
    end
    drain();
  endtask

  task automatic test_illegal();
    req_valid = 2'b10; rsp_ready = '1;
    req_a[1] = 16'hFFFF; req_b[1] = 16'h1234; req_op[1] = 3'd7;
    cycle();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_res !== 16'h0000) begin
      n_err++; $display("FAIL illegal_op: got %b/%h/%b want 10/0000/1", rsp_valid, rsp_res, rsp_err);
    end
    @(posedge clk); #1;
    m_pend = 0;
    drain();
  endtask

  task automatic test_reset_mid_hold();
    req_valid = 2'b10; rsp_ready = '0;
    req_a[1] = 16'h0101; req_b[1] = 16'h0202; req_op[1] = 3'd0;
    cycle();
    req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== '0 || rsp_res !== '0) begin
      n_err++; $display("FAIL async_reset: got %b/%h want 00/0000", rsp_valid, rsp_res);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b11; rsp_ready = '1;
    cycle();
    n_cmp++;
    if (last_xfer != 0) begin
      n_err++; $display("FAIL reset_first_grant: got %0d want 0", last_xfer);
    end
    drain();
  endtask

  task automatic test_sweep();
    int routed_bad = 0;
    rsp_ready = '1;
    for (int op = 0; op < 7; op++) begin
      for (int r = 0; r < NREQ; r++) begin
        req_valid = '0; req_valid[r] = 1'b1;
        req_a[r] = 16'h006A; req_b[r] = 16'h003B; req_op[r] = 3'(op);
        cycle();
        req_valid = '0;
        @(negedge clk);
        if (rsp_valid !== (NREQ'(1) << r)) routed_bad++;
        @(posedge clk); #1;
        m_pend = 0;
      end
    end
    n_cmp++;
    if (routed_bad != 0) begin
      n_err++; $display("FAIL sweep_route: %0d misrouted want 0", routed_bad);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[i] = WIDTH'($urandom); req_b[i] = WIDTH'($urandom); req_op[i] = 3'($urandom);
      end
      cycle();
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_op = '0;
    last_xfer = -1;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid_hold();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
